ibuffer: RTL

//  Instruction buffer between the fetch unit and ctrlblock. Decouples fetch from decode.

---
 rtl/ibuffer_if.sv | 42 ++++
 rtl/ibuffer.sv | 79 +++++++
 2 files changed

// File: rtl/ibuffer_if.sv
// ibuffer_if
//   Bundles the fetch-side push handshake and the ctrlblock-side pop handshake of
//   the instruction buffer.
//   Modports:
//     master - driven by the fetch unit / ctrlblock side (pushes entries, pops head)
//     slave  - the buffer itself
//   Signals:
//     fetch_valid/fetch_ready/fetch_inst/fetch_pc  push handshake and payload
//     flush                                        redirect, discard everything
//     ibuffer_instr_valid/ibuffer_instr_ready      pop handshake
//     ibuffer_inst_out/ibuffer_pc_out              head entry payload
//     ibuffer_count                                current occupancy
interface ibuffer_if #(
  parameter int DEPTH      = 8,
  parameter int INST_WIDTH = 32,
  parameter int PC_WIDTH   = 48
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  fetch_valid;
  logic                  fetch_ready;
  logic [INST_WIDTH-1:0] fetch_inst;
  logic [PC_WIDTH-1:0]   fetch_pc;
  logic                  flush;
  logic                  ibuffer_instr_valid;
  logic                  ibuffer_instr_ready;
  logic [INST_WIDTH-1:0] ibuffer_inst_out;
  logic [PC_WIDTH-1:0]   ibuffer_pc_out;
  logic [CW-1:0]         ibuffer_count;

  modport master (
    output fetch_valid, fetch_inst, fetch_pc, flush, ibuffer_instr_ready,
    input  fetch_ready, ibuffer_instr_valid, ibuffer_inst_out, ibuffer_pc_out,
           ibuffer_count
  );

  modport slave (
    input  fetch_valid, fetch_inst, fetch_pc, flush, ibuffer_instr_ready,
    output fetch_ready, ibuffer_instr_valid, ibuffer_inst_out, ibuffer_pc_out,
           ibuffer_count
  );
endinterface

// File: rtl/ibuffer.sv
// ibuffer
//   Circular first-word-fall-through instruction buffer between fetch and ctrlblock.
//   The head entry drives the outputs directly; a redirect flush empties the buffer
//   in a single cycle.
//   Ports:
//     clock    - rising-edge clock
//     reset_n  - asynchronous active-low reset
//     bus      - ibuffer_if.slave (push/pop handshakes, flush, head payload, count)
module ibuffer #(
  parameter int DEPTH      = 8,
  parameter int INST_WIDTH = 32,
  parameter int PC_WIDTH   = 48
) (
  input  logic      clock,
  input  logic      reset_n,
  ibuffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [INST_WIDTH-1:0] instMem_q [DEPTH];
  logic [PC_WIDTH-1:0]   pcMem_q   [DEPTH];
  logic [PW-1:0]         wrPtr_q, wrPtr_d;
  logic [PW-1:0]         rdPtr_q, rdPtr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push, pop;

  // Ready/valid come from registered occupancy only, so a pop never frees a
  // slot for a push in the same cycle. Flush suppresses both handshakes.
  assign bus.fetch_ready         = (count_q != FULL_COUNT);
  assign bus.ibuffer_instr_valid = (count_q != '0);
  assign bus.ibuffer_inst_out    = instMem_q[rdPtr_q];
  assign bus.ibuffer_pc_out      = pcMem_q[rdPtr_q];
  assign bus.ibuffer_count       = count_q;

  assign push = bus.fetch_valid && bus.fetch_ready && !bus.flush;
  assign pop  = bus.ibuffer_instr_valid && bus.ibuffer_instr_ready && !bus.flush;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (bus.flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PW'(1);
      if (pop)  rdPtr_d = rdPtr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is cleared only by reset; flush just rewinds the pointers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instMem_q[i] <= '0;
        pcMem_q[i]   <= '0;
      end
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (push) begin
        instMem_q[wrPtr_q] <= bus.fetch_inst;
        pcMem_q[wrPtr_q]   <= bus.fetch_pc;
      end
    end
  end
endmodule
